// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx transmitter between NUM_REQ byte
// producers. Requesters hand over bytes through valid/ready handshakes; the
// arbiter launches one frame at a time and counts baud ticks so a new start
// is only issued after the frame plus an idle gap has gone out on the line.
// Build option: define UART_TX_ARB_PRIORITY_EN to replace round-robin with
// fixed priority (lowest valid index always wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = 11,
    parameter int GAP_TICKS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_psel,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       baud_tick,
    output logic                       start,
    output logic [7:0]                 data,
    output logic                       p_sel,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);

    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int MAX_TICKS = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FRAME  = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic [7:0]        pick_data;
    logic              pick_psel;
    logic [7:0]        data_n;
    logic              p_sel_n;
    logic [ID_W-1:0]   grant_n;

    // Find the requester that would win arbitration this cycle.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
`ifdef UART_TX_ARB_PRIORITY_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(i);
            end
        end
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`endif
    end

    // Select the byte and parity choice belonging to the winning requester.
    always_comb begin
        pick_data = 8'h00;
        pick_psel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_data = req_data[8*i +: 8];
                pick_psel = req_psel[i];
            end
        end
    end

    // Next-state logic and the combinational handshake/strobe outputs.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rr_ptr_n   = rr_ptr;
        data_n     = data;
        p_sel_n    = p_sel;
        grant_n    = grant_id;
        req_ready  = '0;
        start      = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_found) begin
                    req_ready = ONE_HOT0 << pick_idx;
                    data_n    = pick_data;
                    p_sel_n   = pick_psel;
                    grant_n   = pick_idx;
                    rr_ptr_n  = pick_idx;
                    state_n   = LAUNCH;
                end
            end
            LAUNCH: begin
                start = 1'b1;
                if (baud_tick) begin
                    cnt_n   = '0;
                    state_n = FRAME;
                end
            end
            FRAME: begin
                if (baud_tick) begin
                    if (cnt == FRAME_LAST) begin
                        frame_done = 1'b1;
                        cnt_n      = '0;
                        state_n    = (GAP_TICKS == 0) ? IDLE : GAP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (cnt == GAP_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter, pointer and the per-frame held transmitter inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            data     <= 8'h00;
            p_sel    <= 1'b0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rr_ptr   <= rr_ptr_n;
            data     <= data_n;
            p_sel    <= p_sel_n;
            grant_id <= grant_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiters (GAP_TICKS=1 and GAP_TICKS=0) driven by
// directed stimulus and checked every cycle against a transaction-level
// model, plus literal expectations for grant order and tick spacing.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic        baud_tick;
    logic [3:0]  req_valid, req_psel, req_ready;
    logic [31:0] req_data;
    logic        start, p_sel, busy, frame_done;
    logic [7:0]  data;
    logic [1:0]  grant_id;

    logic [3:0]  v0, p0, r0;
    logic [31:0] d0;
    logic        start0, psel0, busy0, fd0;
    logic [7:0]  data0;
    logic [1:0]  gid0;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(11), .GAP_TICKS(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_psel(req_psel), .req_ready(req_ready), .baud_tick(baud_tick),
        .start(start), .data(data), .p_sel(p_sel), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(11), .GAP_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_data(d0),
        .req_psel(p0), .req_ready(r0), .baud_tick(baud_tick),
        .start(start0), .data(data0), .p_sel(psel0), .busy(busy0),
        .grant_id(gid0), .frame_done(fd0)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick every third clock, changed just after the active edge.
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 3;
            baud_tick = (div == 0);
        end
    end

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_assert++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endfunction

    // Transaction-level model: idle / waiting for launch tick / ticks left.
    typedef struct {
        bit         busy;
        bit         launch;
        int         left;
        logic [7:0] data;
        bit         psel;
        int         gid;
        int         ptr;
    } model_t;

    model_t m1, m0;
    bit     model_live = 0;

    function automatic int modelPick(model_t m, logic [3:0] v);
        int g;
        g = -1;
`ifdef UART_TX_ARB_PRIORITY_EN
        for (int i = 3; i >= 0; i--) if (v[i]) g = i;
`else
        for (int k = 4; k >= 1; k--) if (v[(m.ptr + k) % 4]) g = (m.ptr + k) % 4;
`endif
        return g;
    endfunction

    function automatic model_t modelStep(model_t m, logic rst, logic [3:0] v, logic [31:0] d,
                                         logic [3:0] p, logic tick, int gap);
        model_t n;
        int g;
        n = m;
        if (rst) begin
            n.busy = 0; n.launch = 0; n.left = 0; n.data = 8'h00;
            n.psel = 0; n.gid = 0; n.ptr = 3;
        end else if (!m.busy) begin
            g = modelPick(m, v);
            if (g >= 0) begin
                n.busy = 1; n.launch = 1; n.data = d[8*g +: 8];
                n.psel = p[g]; n.gid = g; n.ptr = g;
            end
        end else if (m.launch) begin
            if (tick) begin
                n.launch = 0;
                n.left   = 11 + gap;
            end
        end else if (tick) begin
            n.left = m.left - 1;
            if (n.left == 0) n.busy = 0;
        end
        return n;
    endfunction

    function automatic void compareModel(string tag, model_t m, int gap, logic [3:0] v,
                                         logic [3:0] rdy, logic st, logic bsy, logic fd,
                                         logic [7:0] dt, logic ps, logic [1:0] gid);
        int g;
        logic [3:0] exp_rdy;
        g = modelPick(m, v);
        exp_rdy = (!m.busy && g >= 0) ? (4'b0001 << g) : 4'b0000;
        checkOutput({tag, "_req_ready"}, rdy, exp_rdy);
        checkOutput({tag, "_start"}, st, m.launch);
        checkOutput({tag, "_busy"}, bsy, m.busy);
        checkOutput({tag, "_frame_done"}, fd, m.busy && !m.launch && baud_tick && (m.left == gap + 1));
        checkOutput({tag, "_data"}, dt, m.data);
        checkOutput({tag, "_p_sel"}, ps, m.psel);
        checkOutput({tag, "_grant_id"}, gid, m.gid);
    endfunction

    // Advance both models on each active edge with the inputs the DUTs see.
    always @(posedge clk) begin
        m1 = modelStep(m1, reset, req_valid, req_data, req_psel, baud_tick, 1);
        m0 = modelStep(m0, reset, v0, d0, p0, baud_tick, 0);
        model_live = 1;
    end

    // Compare both DUTs against their models mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            compareModel("gap1", m1, 1, req_valid, req_ready, start, busy, frame_done, data, p_sel, grant_id);
            compareModel("gap0", m0, 0, v0, r0, start0, busy0, fd0, data0, psel0, gid0);
        end
    end

    int acc_id[$];
    int acc_inc[$];
    int acc_exc[$];
    int acc0_id[$];
    int tick_cnt = 0;

    // Log every accepted transfer and the baud-tick count around it.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_id.push_back(i);
                    acc_inc.push_back(tick_cnt + (baud_tick ? 1 : 0));
                    acc_exc.push_back(tick_cnt);
                end
                if (v0[i] && r0[i]) acc0_id.push_back(i);
            end
        end
        if (baud_tick) tick_cnt++;
    end

    task automatic applyStimulus(input int id, input logic [7:0] b, input logic ps);
        req_valid[id]       = 1'b1;
        req_data[8*id +: 8] = b;
        req_psel[id]        = ps;
    endtask

    task automatic waitIdle(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!busy && !busy0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput({name, "_idle_timeout"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, ft, gt, rc, grants, exp_order[5], exp_pri[3];
        bit seen_done, finished, chk_next, acc, acc3, raised, done;

        reset = 1'b1;
        req_valid = '0; req_psel = '0; req_data = '0;
        v0 = '0; p0 = '0; d0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_p_sel", p_sel, 0);
        checkOutput("reset_grant_id", grant_id, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_req_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin fairness with all four requesters valid.
        $display("[TB] round-robin fairness");
        base = acc_id.size();
        req_valid = 4'hF;
        req_data  = 32'h1312_1110;
        req_psel  = 4'b0101;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (acc_id.size() >= base + 5) break;
        end
        req_valid = '0;
        exp_order = '{0, 1, 2, 3, 0};
        if (acc_id.size() < base + 5) begin
            checkOutput("rr_timeout", acc_id.size(), base + 5);
        end else begin
            for (int k = 0; k < 5; k++)
                checkOutput($sformatf("rr_order%0d", k), acc_id[base+k], exp_order[k]);
            for (int k = 1; k < 5; k++)
                checkOutput($sformatf("rr_ticks%0d", k), acc_exc[base+k] - acc_inc[base+k-1] - 1, 12);
        end
        waitIdle("rr");

        // Single byte from requester 2.
        $display("[TB] single byte");
        applyStimulus(2, 8'hA5, 1'b1);
        ft = 0; gt = 0; rc = 0; seen_done = 0; finished = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (req_ready[2]) rc++;
            acc = req_ready[2] & req_valid[2];
            if (busy && !start && !seen_done && baud_tick) ft++;
            else if (busy && seen_done && baud_tick) gt++;
            if (frame_done) begin
                seen_done = 1;
                checkOutput("single_data", data, 8'hA5);
                checkOutput("single_p_sel", p_sel, 1);
            end
            if (seen_done && !busy) begin
                finished = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (acc) req_valid[2] = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("single_finished", finished, 1);
        checkOutput("single_ready_cycles", rc, 1);
        checkOutput("single_frame_ticks", ft, 11);
        checkOutput("single_gap_ticks", gt, 1);
        checkOutput("single_grant", acc_id[acc_id.size()-1], 2);

        // GAP_TICKS=0 instance: three bytes back-to-back from requester 1.
        $display("[TB] back-to-back, no gap");
        base = acc0_id.size();
        v0[1] = 1'b1; d0[15:8] = 8'hB0; p0[1] = 1'b0;
        grants = 0; chk_next = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (chk_next) begin
                checkOutput("gap0_next_accept", r0, 4'b0010);
                chk_next = 0;
            end
            if (fd0) chk_next = 1;
            acc = r0[1] & v0[1];
            @(posedge clk);
            #1;
            if (acc) begin
                grants++;
                if (grants == 3) begin
                    v0[1] = 1'b0;
                    break;
                end
                d0[15:8] = 8'(8'hB0 + grants);
            end
        end
        checkOutput("gap0_grant_count", grants, 3);
        waitIdle("gap0");
        for (int k = base; k < acc0_id.size(); k++)
            checkOutput("gap0_grant_id", acc0_id[k], 1);

        // Requester 3 arrives mid-frame of requester 0 and must wait.
        $display("[TB] hold while busy");
        applyStimulus(0, 8'h5C, 1'b0);
        ft = 0; raised = 0; done = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc  = req_ready[0] & req_valid[0];
            acc3 = req_ready[3] & req_valid[3];
            if (busy && !start && baud_tick) ft++;
            if (raised && busy) begin
                checkOutput("hold_ready3", req_ready[3], 0);
                checkOutput("hold_data", data, 8'h5C);
            end
            @(posedge clk);
            #1;
            if (acc) req_valid[0] = 1'b0;
            if (!raised && ft == 4) begin
                applyStimulus(3, 8'h3C, 1'b1);
                raised = 1;
            end
            if (acc3) begin
                req_valid[3] = 1'b0;
                done = 1;
                break;
            end
        end
        checkOutput("hold_granted", done, 1);
        checkOutput("hold_grant_id", acc_id[acc_id.size()-1], 3);
        @(negedge clk);
        checkOutput("hold_new_data", data, 8'h3C);
        waitIdle("hold");

        // Reset in the middle of a frame.
        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h77, 1'b1);
        ft = 0; done = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = req_ready[0] & req_valid[0];
            if (busy && !start && baud_tick) ft++;
            @(posedge clk);
            #1;
            if (acc) req_valid[0] = 1'b0;
            if (ft == 5) begin
                done = 1;
                break;
            end
        end
        checkOutput("rst_reached_tick5", done, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'h2322_2120;
        req_psel  = 4'b0000;
        @(negedge clk);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_data", data, 8'h00);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_req_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        checkOutput("rst_first_grant", acc_id[acc_id.size()-1], 0);
        @(negedge clk);
        checkOutput("rst_first_data", data, 8'h20);
        waitIdle("rst");

        // Requesters 0 and 2 continuously valid from a fresh reset.
        $display("[TB] requesters 0 and 2 contending");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base = acc_id.size();
        req_valid = 4'b0101;
        req_data  = 32'h0042_0040;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (acc_id.size() >= base + 3) break;
        end
        req_valid = '0;
`ifdef UART_TX_ARB_PRIORITY_EN
        exp_pri = '{0, 0, 0};
`else
        exp_pri = '{0, 2, 0};
`endif
        if (acc_id.size() < base + 3) begin
            checkOutput("pri_timeout", acc_id.size(), base + 3);
        end else begin
            for (int k = 0; k < 3; k++)
                checkOutput($sformatf("pri_order%0d", k), acc_id[base+k], exp_pri[k]);
        end
        waitIdle("pri");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
